// File: rtl/mips_writeback_queue_if.sv
// Handshake/bus bundle for mips_writeback_queue.
// Forwarding-data signals exist only when WBQ_BYPASS_EN is defined.
interface mips_writeback_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              rs_pending;
    logic              rt_pending;
    logic [CNT_W-1:0]  count;
`ifdef WBQ_BYPASS_EN
    logic [DATA_W-1:0] rs_fwd_data;
    logic [DATA_W-1:0] rt_fwd_data;
`endif

    // Queue side
    modport slave (
        input  flush, in_valid, in_addr, in_data, wr_ready, rs_addr, rt_addr,
        output in_ready, wr_en, wr_addr, wr_data, rs_pending, rt_pending, count
`ifdef WBQ_BYPASS_EN
        , output rs_fwd_data, rt_fwd_data
`endif
    );

    // Producer / register-file / decode side
    modport master (
        output flush, in_valid, in_addr, in_data, wr_ready, rs_addr, rt_addr,
        input  in_ready, wr_en, wr_addr, wr_data, rs_pending, rt_pending, count
`ifdef WBQ_BYPASS_EN
        , input rs_fwd_data, rt_fwd_data
`endif
    );
endinterface

// File: rtl/mips_writeback_queue.sv
// In-order register-file write-back FIFO with per-address pending lookup.
// Define WBQ_BYPASS_EN to add youngest-match forwarding data outputs.
module mips_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic                   clk,
    input logic                   rst_n,
    mips_writeback_queue_if.slave wbq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic push_hs;
    logic push;
    logic pop;

    always_comb begin
        wbq.in_ready = (count_q < CNT_W'(DEPTH));
        wbq.wr_en    = (count_q != '0);
        wbq.wr_addr  = wbq.wr_en ? addr_q[head_q] : '0;
        wbq.wr_data  = wbq.wr_en ? data_q[head_q] : '0;
        wbq.count    = count_q;
        push_hs      = wbq.in_valid && wbq.in_ready;
        push         = push_hs && (wbq.in_addr != '0);
        pop          = wbq.wr_en && wbq.wr_ready;
    end

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (wbq.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                addr_d[tail_q] = wbq.in_addr;
                data_d[tail_q] = wbq.in_data;
                tail_d         = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Walk oldest to youngest so the last match left standing is the youngest.
    logic [PTR_W-1:0] lk_idx;
    always_comb begin
        wbq.rs_pending = 1'b0;
        wbq.rt_pending = 1'b0;
`ifdef WBQ_BYPASS_EN
        wbq.rs_fwd_data = '0;
        wbq.rt_fwd_data = '0;
`endif
        lk_idx = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            lk_idx = head_q + PTR_W'(k);
            if (CNT_W'(k) < count_q) begin
                if ((wbq.rs_addr != '0) && (addr_q[lk_idx] == wbq.rs_addr)) begin
                    wbq.rs_pending = 1'b1;
`ifdef WBQ_BYPASS_EN
                    wbq.rs_fwd_data = data_q[lk_idx];
`endif
                end
                if ((wbq.rt_addr != '0) && (addr_q[lk_idx] == wbq.rt_addr)) begin
                    wbq.rt_pending = 1'b1;
`ifdef WBQ_BYPASS_EN
                    wbq.rt_fwd_data = data_q[lk_idx];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_mips_writeback_queue.sv
// Randomized + directed self-checking bench for mips_writeback_queue against a queue-based model.
// Define WBQ_BYPASS_EN to also check the forwarding data outputs.
module tb_mips_writeback_queue;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    ent_t mq[$];

    mips_writeback_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mips_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .wbq  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic pend(input logic [ADDR_W-1:0] x);
        pend = 1'b0;
        if (x != 0)
            foreach (mq[i]) if (mq[i].a == x) pend = 1'b1;
    endfunction

    function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] x);
        fwd = '0;
        if (x != 0)
            foreach (mq[i]) if (mq[i].a == x) fwd = mq[i].d;
    endfunction

    task automatic check_outputs();
        int n;
        n = mq.size();
        check("in_ready", 32'(bus.in_ready), 32'(n < DEPTH));
        check("wr_en",    32'(bus.wr_en),    32'(n != 0));
        check("wr_addr",  32'(bus.wr_addr),  (n != 0) ? 32'(mq[0].a) : 32'd0);
        check("wr_data",  bus.wr_data,       (n != 0) ? mq[0].d : 32'd0);
        check("count",    32'(bus.count),    32'(n));
        check("rs_pending", 32'(bus.rs_pending), 32'(pend(bus.rs_addr)));
        check("rt_pending", 32'(bus.rt_pending), 32'(pend(bus.rt_addr)));
`ifdef WBQ_BYPASS_EN
        check("rs_fwd", bus.rs_fwd_data, fwd(bus.rs_addr));
        check("rt_fwd", bus.rt_fwd_data, fwd(bus.rt_addr));
`endif
    endtask

    // Called at a negedge: drive, check, take the edge, advance the model.
    task automatic step(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic wrr, input logic fl,
                        input logic [ADDR_W-1:0] rsa, input logic [ADDR_W-1:0] rta);
        logic hs, pp;
        bus.in_valid = v;
        bus.in_addr  = a;
        bus.in_data  = d;
        bus.wr_ready = wrr;
        bus.flush    = fl;
        bus.rs_addr  = rsa;
        bus.rt_addr  = rta;
        #1;
        check_outputs();
        hs = v && (mq.size() < DEPTH);
        pp = wrr && (mq.size() != 0);
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (pp) void'(mq.pop_front());
            if (hs && a != 0) mq.push_back('{a: a, d: d});
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_addr  = '0;
        bus.in_data  = '0;
        bus.wr_ready = 1'b0;
        bus.flush    = 1'b0;
        bus.rs_addr  = 5'd3;
        bus.rt_addr  = 5'd0;
        #3;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Single write, retire with wr_ready high
        step(1, 5'd5, 32'hDEADBEEF, 1, 0, 5'd5, 5'd0);
        check("single_cnt1", 32'(bus.count), 32'd1);
        step(0, 5'd0, 32'd0, 1, 0, 5'd5, 5'd0);
        check("single_cnt0", 32'(bus.count), 32'd0);

        // Fill, attempt a 5th push, then drain in order
        for (int i = 1; i <= 5; i++) step(1, 5'(i), 32'(i * 32'h101), 0, 0, 5'd4, 5'd1);
        check("full_cnt", 32'(bus.count), 32'd4);
        for (int i = 0; i < 5; i++) step(0, 5'd0, 32'd0, 1, 0, 5'd2, 5'd5);

        // $zero write discarded
        step(1, 5'd0, 32'h1234, 1, 0, 5'd0, 5'd0);
        check("zero_cnt", 32'(bus.count), 32'd0);
        step(0, 5'd0, 32'd0, 1, 0, 5'd0, 5'd0);

        // Duplicate address pending/forwarding
        step(1, 5'd7, 32'h11, 0, 0, 5'd7, 5'd7);
        step(1, 5'd7, 32'h22, 0, 0, 5'd7, 5'd8);
        step(0, 5'd0, 32'd0, 0, 0, 5'd7, 5'd7);
        check("dup_pend", 32'(bus.rs_pending), 32'd1);
        for (int i = 0; i < 3; i++) step(0, 5'd0, 32'd0, 1, 0, 5'd7, 5'd0);

        // Push+pop at count 1 repeatedly, wrapping the pointers
        for (int i = 0; i < 9; i++) step(1, 5'(10 + i), $urandom, 1, 0, 5'(10 + i), 5'(9 + i));

        // Flush together with a push
        for (int i = 0; i < 3; i++) step(1, 5'(20 + i), $urandom, 0, 0, 5'd20, 5'd22);
        step(1, 5'd25, 32'h55, 0, 1, 5'd25, 5'd20);
        check("flush_cnt", 32'(bus.count), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

        // Refill, then asynchronous reset between edges
        for (int i = 0; i < 3; i++) step(1, 5'(1 + i), $urandom, 0, 0, 5'd1, 5'd2);
        step(0, 5'd0, 32'd0, 0, 0, 5'd1, 5'd2);
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        check("async_wr_en", 32'(bus.wr_en), 32'd0);
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(i < 2, 5'(3 + i), $urandom, 1, 0, 5'd3, 5'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
